// File: rtl/ex_div_pkg.sv
// ex_div_pkg: shared divider state encodings and handshake constants used by ex, ctrl and ex_div
package ex_div_pkg;
  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;
endpackage

// File: rtl/ex_div_step.sv
// div_step: one restoring radix-2 iteration; rem (shifted partial remainder, WIDTH+1) and dvs (divisor magnitude) in, rem_next and q_bit out
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);
  logic [WIDTH:0] diff;
  assign diff = rem - {1'b0, dvs};
  assign q_bit = ~diff[WIDTH];
  assign rem_next = q_bit ? diff[WIDTH-1:0] : rem[WIDTH-1:0];
endmodule

// File: rtl/ex_div.sv
// ex_div: multi-cycle signed/unsigned divider; clk, rst, signed_div_i, opdata1_i, opdata2_i, start_i, annul_i in; result_o {rem,quo}, ready_o, div_zero_o out
module ex_div
  import ex_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               div_zero_o
);
  localparam int CW = $clog2(WIDTH) + 1;
  div_state_e state, state_n;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] dvd, dvs, rem, quo, rmd;
  logic neg1, neg2, q_bit, last;
  div_step #(.WIDTH(WIDTH)) u_step (
    .rem({rem, dvd[WIDTH-1]}),
    .dvs(dvs),
    .rem_next(rmd),
    .q_bit(q_bit)
  );
  assign last = cnt == CW'(WIDTH - 1);
  assign quo = {dvd[WIDTH-2:0], q_bit};
  always_comb begin
    state_n = state;
    case (state)
      DivFree:   state_n = (start_i == DivStart && !annul_i) ? (opdata2_i == '0 ? DivByZero : DivOn) : DivFree;
      DivByZero: state_n = DivEnd;
      DivOn:     state_n = annul_i ? DivFree : (last ? DivEnd : DivOn);
      DivEnd:    state_n = start_i == DivStart ? DivEnd : DivFree;
      default:   state_n = DivFree;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) state <= DivFree;
    else state <= state_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      dvd <= '0;
      dvs <= '0;
      rem <= '0;
      neg1 <= 1'b0;
      neg2 <= 1'b0;
      result_o <= '0;
      ready_o <= DivResultNotReady;
      div_zero_o <= 1'b0;
    end else begin
      case (state)
        DivFree: begin
          result_o <= '0;
          ready_o <= DivResultNotReady;
          div_zero_o <= 1'b0;
          if (state_n == DivOn) begin
            cnt <= '0;
            rem <= '0;
            dvd <= (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
            dvs <= (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
            neg1 <= signed_div_i & opdata1_i[WIDTH-1];
            neg2 <= signed_div_i & opdata2_i[WIDTH-1];
          end
        end
        DivByZero: begin
          result_o <= '0;
          ready_o <= DivResultReady;
          div_zero_o <= 1'b1;
        end
        DivOn: if (!annul_i) begin
          rem <= rmd;
          dvd <= quo;
          cnt <= cnt + 1'b1;
          if (last) begin
            // neg flags are only set in signed mode, so unsigned results pass through untouched
            result_o <= {neg1 ? -rmd : rmd, (neg1 ^ neg2) ? -quo : quo};
            ready_o <= DivResultReady;
            div_zero_o <= 1'b0;
          end
        end
        DivEnd: if (start_i == DivStop) begin
          result_o <= '0;
          ready_o <= DivResultNotReady;
          div_zero_o <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ex_div.sv
// tb_ex_div: directed self-checking bench for ex_div at WIDTH=32
module tb_ex_div;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic signed_div_i = 1'b0;
  logic [31:0] opdata1_i = '0;
  logic [31:0] opdata2_i = '0;
  logic start_i = 1'b0;
  logic annul_i = 1'b0;
  logic [63:0] result_o;
  logic ready_o;
  logic div_zero_o;
  int errors = 0;
  int checks = 0;
  ex_div #(.WIDTH(32)) dut (
    .clk(clk),
    .rst(rst),
    .signed_div_i(signed_div_i),
    .opdata1_i(opdata1_i),
    .opdata2_i(opdata2_i),
    .start_i(start_i),
    .annul_i(annul_i),
    .result_o(result_o),
    .ready_o(ready_o),
    .div_zero_o(div_zero_o)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic launch(input logic s, input logic [31:0] a, input logic [31:0] b);
    signed_div_i = s;
    opdata1_i = a;
    opdata2_i = b;
    start_i = 1'b1;
  endtask
  task automatic do_div(input string tag, input logic s, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eq, input logic [31:0] er);
    launch(s, a, b);
    repeat (32) tick();
    chk({tag, " ready early"}, 64'(ready_o), 64'd0);
    tick();
    chk({tag, " ready"}, 64'(ready_o), 64'd1);
    chk({tag, " result"}, result_o, {er, eq});
    chk({tag, " div_zero"}, 64'(div_zero_o), 64'd0);
    tick();
    chk({tag, " held result"}, result_o, {er, eq});
    start_i = 1'b0;
    tick();
    chk({tag, " ready drop"}, 64'(ready_o), 64'd0);
    chk({tag, " result clear"}, result_o, 64'd0);
  endtask
  initial begin
    tick();
    tick();
    chk("reset ready", 64'(ready_o), 64'd0);
    chk("reset result", result_o, 64'd0);
    chk("reset div_zero", 64'(div_zero_o), 64'd0);
    rst = 1'b0;
    tick();
    do_div("u 100/7", 1'b0, 32'd100, 32'd7, 32'h0000000E, 32'h00000002);
    do_div("s -7/2", 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF);
    do_div("u -7/2", 1'b0, 32'hFFFFFFF9, 32'd2, 32'h7FFFFFFC, 32'h00000001);
    do_div("s 7/-2", 1'b1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000001);
    do_div("s -7/-2", 1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF);
    do_div("s overflow", 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000);
    do_div("u max/1", 1'b0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'h00000000);
    do_div("u 5/9", 1'b0, 32'd5, 32'd9, 32'h00000000, 32'h00000005);
    launch(1'b0, 32'd123, 32'd0);
    tick();
    chk("zero ready early", 64'(ready_o), 64'd0);
    tick();
    chk("zero ready", 64'(ready_o), 64'd1);
    chk("zero result", result_o, 64'd0);
    chk("zero flag", 64'(div_zero_o), 64'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("zero ready held", 64'(ready_o), 64'd1);
    end
    start_i = 1'b0;
    tick();
    chk("zero ready drop", 64'(ready_o), 64'd0);
    chk("zero flag drop", 64'(div_zero_o), 64'd0);
    launch(1'b0, 32'd100, 32'd7);
    repeat (10) tick();
    annul_i = 1'b1;
    tick();
    annul_i = 1'b0;
    chk("annul ready", 64'(ready_o), 64'd0);
    do_div("after annul 9/3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0);
    launch(1'b1, 32'hFFFFFF00, 32'd3);
    repeat (20) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    start_i = 1'b0;
    chk("mid rst ready", 64'(ready_o), 64'd0);
    chk("mid rst result", result_o, 64'd0);
    chk("mid rst div_zero", 64'(div_zero_o), 64'd0);
    repeat (40) begin
      tick();
      if (ready_o !== 1'b0) chk("mid rst stays idle", 64'(ready_o), 64'd0);
    end
    do_div("after rst 1000/10", 1'b0, 32'd1000, 32'd10, 32'd100, 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
